// File: rtl/voter_pkg.sv
// Shared helpers for the N-channel majority voter: population count,
// counter width and parameter legality.
package voter_pkg;

   localparam int unsigned MIN_CH  = 3;
   localparam int unsigned MAX_CH  = 7;
   localparam int unsigned CNT_N_W = 4;

   function automatic logic [CNT_N_W-1:0] popcount(input logic [MAX_CH-1:0] v);
      logic [CNT_N_W-1:0] c;
      c = '0;
      for (int i = 0; i < int'(MAX_CH); i++) begin
         c = c + CNT_N_W'(v[i]);
      end
      return c;
   endfunction

   // Width of a counter that must reach fault_th.
   function automatic int unsigned cnt_width(input int unsigned fault_th);
      return $clog2(fault_th + 1);
   endfunction

   function automatic bit params_ok(input int unsigned n_ch, input int unsigned w,
                                    input int unsigned fault_th);
      return (n_ch >= MIN_CH) && (n_ch <= MAX_CH) && (w >= 1) && (fault_th >= 1);
   endfunction

endpackage

// File: rtl/chan_fault_tracker.sv
// Per-channel saturating disagreement counter; flags the channel as a mask
// candidate when the post-update count reaches the threshold.
module chan_fault_tracker #(
   parameter int unsigned FAULT_TH = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic clk,
   input  logic resetn,
   input  logic in_valid,
   input  logic clr_fault,
   input  logic masked,
   input  logic disagree,
   output logic cand_c
);

   localparam logic [CNT_W-1:0] TH = CNT_W'(FAULT_TH);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Masked channels keep their count frozen.
   always_comb begin
      cnt_nxt = cnt;
      if (in_valid && !masked) begin
         if (!disagree) begin
            cnt_nxt = '0;
         end else if (cnt != TH) begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   assign cand_c = in_valid && !masked && (cnt_nxt == TH);

   always_ff @(posedge clk) begin
      if (!resetn || clr_fault) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/majority_voter_n.sv
// N-channel bitwise majority voter with registered output and sticky
// per-channel fault masking of persistently disagreeing channels.
module majority_voter_n
   import voter_pkg::*;
#(
   parameter int unsigned N_CH     = 3,
   parameter int unsigned W        = 8,
   parameter int unsigned FAULT_TH = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   input  logic [N_CH*W-1:0] ch_data,
   input  logic              clr_fault,
   output logic              out_valid,
   output logic [W-1:0]      vote_data,
   output logic              no_majority,
   output logic [N_CH-1:0]   fault_mask,
   output logic              fault_event
);

   localparam int unsigned CNT_W = cnt_width(FAULT_TH);

   generate
      if (!params_ok(N_CH, W, FAULT_TH)) begin : g_bad_params
         $error("majority_voter_n: N_CH must be 3..7, W >= 1, FAULT_TH >= 1");
      end
   endgenerate

   logic [N_CH-1:0]    active;
   logic [CNT_N_W-1:0] a_cnt;
   logic [CNT_N_W-1:0] ones;
   logic [N_CH-1:0]    col [W];
   logic [W-1:0]       vote_c;
   logic [W-1:0]       tie_c;
   logic [N_CH-1:0]    disagree;
   logic [N_CH-1:0]    cand;
   logic [N_CH-1:0]    new_mask;
   logic               found;
   logic               mask_set_c;

   assign active = ~fault_mask;
   assign a_cnt  = popcount(MAX_CH'(active));

   // Gather each bit column from the active channels only.
   always_comb begin
      col = '{default: '0};
      for (int b = 0; b < int'(W); b++) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            col[b][i] = ch_data[i*W + b] & active[i];
         end
      end
   end

   // Ties (even active count only) hold the previous voted bit.
   always_comb begin
      vote_c = vote_data;
      tie_c  = '0;
      ones   = '0;
      for (int b = 0; b < int'(W); b++) begin
         ones = popcount(MAX_CH'(col[b]));
         if ({ones, 1'b0} > {1'b0, a_cnt}) begin
            vote_c[b] = 1'b1;
         end else if ({ones, 1'b0} < {1'b0, a_cnt}) begin
            vote_c[b] = 1'b0;
         end else begin
            tie_c[b] = 1'b1;
         end
      end
   end

   generate
      for (genvar g = 0; g < int'(N_CH); g++) begin : g_trk
         assign disagree[g] = active[g] && (ch_data[g*W +: W] != vote_c);

         chan_fault_tracker #(
            .FAULT_TH (FAULT_TH),
            .CNT_W    (CNT_W)
         ) u_trk (
            .clk       (clk),
            .resetn    (resetn),
            .in_valid  (in_valid),
            .clr_fault (clr_fault),
            .masked    (fault_mask[g]),
            .disagree  (disagree[g]),
            .cand_c    (cand[g])
         );
      end
   endgenerate

   // Lowest-index candidate wins; never drop below two active channels.
   always_comb begin
      new_mask = '0;
      found    = 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (cand[i] && !found) begin
            new_mask[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign mask_set_c = found && (a_cnt > CNT_N_W'(2));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_valid   <= 1'b0;
         vote_data   <= '0;
         no_majority <= 1'b0;
         fault_mask  <= '0;
         fault_event <= 1'b0;
      end else begin
         out_valid   <= in_valid;
         fault_event <= 1'b0;
         if (in_valid) begin
            vote_data   <= vote_c;
            no_majority <= |tie_c;
         end
         if (clr_fault) begin
            fault_mask <= '0;
         end else if (mask_set_c) begin
            fault_mask  <= fault_mask | new_mask;
            fault_event <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_majority_voter_n.sv
// Directed bench for majority_voter_n with N_CH=3, W=8, FAULT_TH=4.
module tb_majority_voter_n;

   localparam int unsigned N_CH     = 3;
   localparam int unsigned W        = 8;
   localparam int unsigned FAULT_TH = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic              in_valid;
   logic [N_CH*W-1:0] ch_data;
   logic              clr_fault;
   logic              out_valid;
   logic [W-1:0]      vote_data;
   logic              no_majority;
   logic [N_CH-1:0]   fault_mask;
   logic              fault_event;

   int checks = 0;
   int errors = 0;

   majority_voter_n #(
      .N_CH     (N_CH),
      .W        (W),
      .FAULT_TH (FAULT_TH)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .ch_data     (ch_data),
      .clr_fault   (clr_fault),
      .out_valid   (out_valid),
      .vote_data   (vote_data),
      .no_majority (no_majority),
      .fault_mask  (fault_mask),
      .fault_event (fault_event)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic v);
      ch_data  = {d2, d1, d0};
      in_valid = v;
   endtask

   task automatic do_reset;
      resetn    = 1'b0;
      in_valid  = 1'b0;
      clr_fault = 1'b0;
      ch_data   = '0;
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (vote_data !== 8'h00) begin errors++; $display("FAIL rst_vote got %h exp 00", vote_data); end
      checks++; if (no_majority !== 1'b0) begin errors++; $display("FAIL rst_no_maj got %b exp 0", no_majority); end
      checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL rst_mask got %b exp 000", fault_mask); end
      checks++; if (fault_event !== 1'b0) begin errors++; $display("FAIL rst_event got %b exp 0", fault_event); end
   endtask

   task automatic test_unanimous;
      do_reset();
      drive(8'hA5, 8'hA5, 8'hA5, 1'b1);
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL a5_valid got %b exp 1", out_valid); end
      checks++; if (vote_data !== 8'hA5) begin errors++; $display("FAIL a5_vote got %h exp a5", vote_data); end
      checks++; if (no_majority !== 1'b0) begin errors++; $display("FAIL a5_no_maj got %b exp 0", no_majority); end
      checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL a5_mask got %b exp 000", fault_mask); end
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
      checks++; if (vote_data !== 8'hA5) begin errors++; $display("FAIL idle_hold got %h exp a5", vote_data); end
   endtask

   task automatic test_bitwise_vote;
      do_reset();
      drive(8'hFF, 8'h0F, 8'h3C, 1'b1);
      step();
      checks++; if (vote_data !== 8'h3F) begin errors++; $display("FAIL mix_vote got %h exp 3f", vote_data); end
      checks++; if (no_majority !== 1'b0) begin errors++; $display("FAIL mix_no_maj got %b exp 0", no_majority); end
      checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL mix_mask got %b exp 000", fault_mask); end
      // ch0 already at 1, so three more disagreements saturate it
      for (int k = 1; k <= 3; k++) begin
         drive(8'h00, 8'hAA, 8'hAA, 1'b1);
         step();
         checks++; if (vote_data !== 8'hAA) begin errors++; $display("FAIL cnt1_vote[%0d] got %h exp aa", k, vote_data); end
         checks++; if (fault_mask !== ((k == 3) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL cnt1_mask[%0d] got %b exp %b", k, fault_mask, (k == 3) ? 3'b001 : 3'b000); end
         checks++; if (fault_event !== (k == 3)) begin errors++; $display("FAIL cnt1_event[%0d] got %b exp %b", k, fault_event, (k == 3)); end
      end
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      step();
      checks++; if (fault_event !== 1'b0) begin errors++; $display("FAIL cnt1_event_drop got %b exp 0", fault_event); end
   endtask

   task automatic test_fault_mask;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         drive(8'h55, 8'h55, 8'h00, 1'b1);
         step();
         checks++; if (vote_data !== 8'h55) begin errors++; $display("FAIL fm_vote[%0d] got %h exp 55", k, vote_data); end
         checks++; if (fault_mask !== ((k == 4) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL fm_mask[%0d] got %b exp %b", k, fault_mask, (k == 4) ? 3'b100 : 3'b000); end
         checks++; if (fault_event !== (k == 4)) begin errors++; $display("FAIL fm_event[%0d] got %b exp %b", k, fault_event, (k == 4)); end
      end
      drive(8'h55, 8'h55, 8'hFF, 1'b1);
      step();
      checks++; if (vote_data !== 8'h55) begin errors++; $display("FAIL fm5_vote got %h exp 55", vote_data); end
      checks++; if (no_majority !== 1'b0) begin errors++; $display("FAIL fm5_no_maj got %b exp 0", no_majority); end
      checks++; if (fault_event !== 1'b0) begin errors++; $display("FAIL fm5_event got %b exp 0", fault_event); end
      checks++; if (fault_mask !== 3'b100) begin errors++; $display("FAIL fm5_mask got %b exp 100", fault_mask); end
   endtask

   // Runs straight after test_fault_mask: ch2 masked, last vote 0x55.
   task automatic test_tie_suppress;
      for (int k = 1; k <= 4; k++) begin
         drive(8'hF0, 8'h0F, 8'h00, 1'b1);
         step();
         checks++; if (vote_data !== 8'h55) begin errors++; $display("FAIL tie_vote[%0d] got %h exp 55", k, vote_data); end
         checks++; if (no_majority !== 1'b1) begin errors++; $display("FAIL tie_no_maj[%0d] got %b exp 1", k, no_majority); end
         checks++; if (fault_mask !== 3'b100) begin errors++; $display("FAIL tie_mask[%0d] got %b exp 100", k, fault_mask); end
         checks++; if (fault_event !== 1'b0) begin errors++; $display("FAIL tie_event[%0d] got %b exp 0", k, fault_event); end
      end
   endtask

   task automatic test_recovery;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         if (k == 3) drive(8'hAA, 8'hAA, 8'hAA, 1'b1);
         else        drive(8'hAA, 8'hAA, 8'h00, 1'b1);
         step();
         checks++; if (vote_data !== 8'hAA) begin errors++; $display("FAIL rec_vote[%0d] got %h exp aa", k, vote_data); end
         checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL rec_mask[%0d] got %b exp 000", k, fault_mask); end
         checks++; if (fault_event !== 1'b0) begin errors++; $display("FAIL rec_event[%0d] got %b exp 0", k, fault_event); end
         drive(8'h00, 8'h00, 8'h00, 1'b0);
         step();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rec_idle_valid[%0d] got %b exp 0", k, out_valid); end
         checks++; if (vote_data !== 8'hAA) begin errors++; $display("FAIL rec_idle_hold[%0d] got %h exp aa", k, vote_data); end
      end
   endtask

   task automatic test_clear_and_reset;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         drive(8'h55, 8'h55, 8'h00, 1'b1);
         step();
      end
      checks++; if (fault_mask !== 3'b100) begin errors++; $display("FAIL clr_pre_mask got %b exp 100", fault_mask); end
      // Voted with ch2 excluded: every differing bit of 0x11/0x22 ties and holds 0x55
      clr_fault = 1'b1;
      drive(8'h11, 8'h22, 8'h33, 1'b1);
      step();
      clr_fault = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_valid got %b exp 1", out_valid); end
      checks++; if (vote_data !== 8'h11) begin errors++; $display("FAIL clr_vote got %h exp 11", vote_data); end
      checks++; if (no_majority !== 1'b1) begin errors++; $display("FAIL clr_no_maj got %b exp 1", no_majority); end
      checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL clr_mask got %b exp 000", fault_mask); end
      for (int k = 1; k <= 4; k++) begin
         drive(8'h55, 8'h55, 8'h00, 1'b1);
         step();
         checks++; if (fault_mask !== ((k == 4) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL clr_cnt_mask[%0d] got %b exp %b", k, fault_mask, (k == 4) ? 3'b100 : 3'b000); end
      end
      resetn    = 1'b0;
      clr_fault = 1'b1;
      drive(8'hFF, 8'h00, 8'hFF, 1'b1);
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
      checks++; if (vote_data !== 8'h00) begin errors++; $display("FAIL mid_rst_vote got %h exp 00", vote_data); end
      checks++; if (no_majority !== 1'b0) begin errors++; $display("FAIL mid_rst_no_maj got %b exp 0", no_majority); end
      checks++; if (fault_mask !== 3'b000) begin errors++; $display("FAIL mid_rst_mask got %b exp 000", fault_mask); end
      checks++; if (fault_event !== 1'b0) begin errors++; $display("FAIL mid_rst_event got %b exp 0", fault_event); end
      resetn    = 1'b1;
      clr_fault = 1'b0;
      drive(8'h00, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      resetn    = 1'b0;
      in_valid  = 1'b0;
      clr_fault = 1'b0;
      ch_data   = '0;
      test_reset();
      test_unanimous();
      test_bitwise_vote();
      test_fault_mask();
      test_tie_suppress();
      test_recovery();
      test_clear_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
